// File: rtl/serial_bridge_pkg.sv
// Shared constants and state encodings for serial_bridge.
// Defining SERIAL_BRIDGE_PARITY_EN adds a PARITY state to both UART paths.
package serial_bridge_pkg;

  localparam int   DATA_BITS       = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

`ifdef SERIAL_BRIDGE_PARITY_EN
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} txState_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rxState_t;
`else
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
`endif

  function automatic logic evenParity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/serial_bridge_sync_fifo.sv
// Show-ahead synchronous FIFO; the head word is valid whenever empty is low.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] pushData,
  input  logic         pop,
  output logic [W-1:0] popData,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW:0]   count;
  logic          doPush;
  logic          doPop;

  // A full FIFO still takes a push when the same cycle frees a slot.
  assign doPush  = push && (!full || pop);
  assign doPop   = pop && !empty;
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign popData = mem[rdPtr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/serial_bridge.sv
// Processor serial port to UART bridge with TX and RX byte FIFOs.
// Define SERIAL_BRIDGE_PARITY_EN for 11-bit frames carrying an even-parity bit.
module serial_bridge
  import serial_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clock,
  input  logic       reset,
  output logic [7:0] serial_out_data,
  output logic       serial_valid_out,
  input  logic       serial_rden_in,
  output logic       serial_ready_out,
  input  logic [7:0] serial_in_data,
  input  logic       serial_wren_in,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       rx_overrun,
  output logic       rx_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  logic [7:0] txHead, rxHead;
  logic       txFull, txEmpty, txPush, txPop;
  logic       rxFull, rxEmpty, rxPush;

  txState_t      txState;
  logic [CW-1:0] txCnt;
  logic [2:0]    txBit;
  logic [7:0]    txShift;
  logic          uartTxReg;
  logic          txBaudDone;

  rxState_t      rxState;
  logic [CW-1:0] rxCnt;
  logic [2:0]    rxBit;
  logic [7:0]    rxShift;
  logic          rxMeta, rxSync;
  logic          rxWaitHigh;
  logic          rxBaudDone;
  logic          rxFrameOk;
  logic          overrunReg, frameErrReg;
`ifdef SERIAL_BRIDGE_PARITY_EN
  logic          rxParityBad;
`endif

  sync_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) txFifo (
    .clock(clock), .reset(reset), .push(txPush), .pushData(serial_in_data),
    .pop(txPop), .popData(txHead), .full(txFull), .empty(txEmpty)
  );

  sync_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) rxFifo (
    .clock(clock), .reset(reset), .push(rxPush), .pushData(rxShift),
    .pop(serial_rden_in), .popData(rxHead), .full(rxFull), .empty(rxEmpty)
  );

  // Writes while not ready are ignored, so the TX FIFO never sees a push when full.
  assign txPush           = serial_wren_in && !txFull;
  assign txPop            = (txState == TX_IDLE) && !txEmpty;
  assign serial_ready_out = !txFull;
  assign serial_valid_out = !rxEmpty;
  assign serial_out_data  = rxEmpty ? 8'h00 : rxHead;
  assign uart_tx          = uartTxReg;
  assign rx_overrun       = overrunReg;
  assign rx_frame_err     = frameErrReg;

  assign txBaudDone = (txCnt == BAUD_LAST);
  assign rxBaudDone = (rxCnt == BAUD_LAST);
`ifdef SERIAL_BRIDGE_PARITY_EN
  assign rxFrameOk  = rxSync && !rxParityBad;
`else
  assign rxFrameOk  = rxSync;
`endif
  assign rxPush = (rxState == RX_STOP) && rxBaudDone && rxFrameOk;

  always_ff @(posedge clock) begin
    if (reset) begin
      txState   <= TX_IDLE;
      txCnt     <= '0;
      txBit     <= '0;
      txShift   <= '0;
      uartTxReg <= UART_IDLE_LEVEL;
    end else begin
      txCnt <= txBaudDone ? '0 : txCnt + CW'(1);
      case (txState)
        TX_IDLE: begin
          txCnt     <= '0;
          uartTxReg <= UART_IDLE_LEVEL;
          if (!txEmpty) begin
            txShift   <= txHead;
            uartTxReg <= ~UART_IDLE_LEVEL;
            txState   <= TX_START;
          end
        end
        TX_START: begin
          if (txBaudDone) begin
            txBit     <= '0;
            uartTxReg <= txShift[0];
            txState   <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (txBaudDone) begin
            if (txBit == LAST_BIT) begin
`ifdef SERIAL_BRIDGE_PARITY_EN
              uartTxReg <= evenParity(txShift);
              txState   <= TX_PARITY;
`else
              uartTxReg <= UART_IDLE_LEVEL;
              txState   <= TX_STOP;
`endif
            end else begin
              txBit     <= txBit + 3'd1;
              uartTxReg <= txShift[txBit + 3'd1];
            end
          end
        end
`ifdef SERIAL_BRIDGE_PARITY_EN
        TX_PARITY: begin
          if (txBaudDone) begin
            uartTxReg <= UART_IDLE_LEVEL;
            txState   <= TX_STOP;
          end
        end
`endif
        TX_STOP: begin
          if (txBaudDone) txState <= TX_IDLE;
        end
        default: txState <= TX_IDLE;
      endcase
    end
  end

  // After a stop-bit error the receiver ignores the line until it is seen high again.
  always_ff @(posedge clock) begin
    if (reset) begin
      rxMeta      <= UART_IDLE_LEVEL;
      rxSync      <= UART_IDLE_LEVEL;
      rxState     <= RX_IDLE;
      rxCnt       <= '0;
      rxBit       <= '0;
      rxShift     <= '0;
      rxWaitHigh  <= 1'b0;
      overrunReg  <= 1'b0;
      frameErrReg <= 1'b0;
`ifdef SERIAL_BRIDGE_PARITY_EN
      rxParityBad <= 1'b0;
`endif
    end else begin
      rxMeta <= uart_rx;
      rxSync <= rxMeta;
      rxCnt  <= rxBaudDone ? '0 : rxCnt + CW'(1);
      case (rxState)
        RX_IDLE: begin
          rxCnt <= '0;
          if (rxWaitHigh) begin
            if (rxSync) rxWaitHigh <= 1'b0;
          end else if (!rxSync) begin
            rxState <= RX_START;
          end
        end
        RX_START: begin
          if (rxCnt == HALF_LAST) begin
            rxCnt   <= '0;
            rxBit   <= '0;
            rxState <= rxSync ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (rxBaudDone) begin
            rxShift[rxBit] <= rxSync;
            if (rxBit == LAST_BIT) begin
`ifdef SERIAL_BRIDGE_PARITY_EN
              rxState <= RX_PARITY;
`else
              rxState <= RX_STOP;
`endif
            end else begin
              rxBit <= rxBit + 3'd1;
            end
          end
        end
`ifdef SERIAL_BRIDGE_PARITY_EN
        RX_PARITY: begin
          if (rxBaudDone) begin
            rxParityBad <= (rxSync != evenParity(rxShift));
            rxState     <= RX_STOP;
          end
        end
`endif
        RX_STOP: begin
          if (rxBaudDone) begin
            rxState <= RX_IDLE;
            if (!rxSync) begin
              frameErrReg <= 1'b1;
              rxWaitHigh  <= 1'b1;
            end else if (!rxFrameOk) begin
              frameErrReg <= 1'b1;
            end else if (rxFull && !serial_rden_in) begin
              overrunReg <= 1'b1;
            end
          end
        end
        default: rxState <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bridge.sv
// Self-checking bench for serial_bridge in its default 8N1 build (CLKS_PER_BIT=4, FIFO_DEPTH=16).
// A cycle-level reference model predicts every output; directed cases pin the model with literals.
module tb_serial_bridge;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * CPB;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] serialOutData;
  logic       serialValidOut;
  logic       serialRdenIn = 1'b0;
  logic       serialReadyOut;
  logic [7:0] serialInData = 8'h00;
  logic       serialWrenIn = 1'b0;
  logic       uartRx = 1'b1;
  logic       uartTx;
  logic       rxOverrun;
  logic       rxFrameErr;

  serial_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .serial_out_data(serialOutData), .serial_valid_out(serialValidOut),
    .serial_rden_in(serialRdenIn), .serial_ready_out(serialReadyOut),
    .serial_in_data(serialInData), .serial_wren_in(serialWrenIn),
    .uart_rx(uartRx), .uart_tx(uartTx),
    .rx_overrun(rxOverrun), .rx_frame_err(rxFrameErr)
  );

  initial forever #5 clock = ~clock;

  int         cyc = 0;
  int         testsRun = 0;
  int         failures = 0;
  logic       modelLive = 1'b0;
  logic [7:0] txQ[$];
  logic [7:0] rxQ[$];
  logic [7:0] txLog[$];
  int         mTxStart = -100000;
  int         mTxIdleAt = 0;
  logic [7:0] mTxByte = 8'h00;
  logic       mOverrun = 1'b0;
  logic       mFrameErr = 1'b0;
  logic       rxPending = 1'b0;
  int         rxEvtSeq = 0;
  int         rxSeenSeq = 0;
  logic [7:0] rxEvtByte = 8'h00;
  logic       rxEvtStopOk = 1'b1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  // Line level a UART must show: start 0, data LSB first, stop 1, idle 1 otherwise.
  function automatic logic expectedTx();
    int off;
    off = cyc - mTxStart;
    if (off < 0 || off >= FRAME) return 1'b1;
    if (off / CPB == 0) return 1'b0;
    if (off / CPB == 9) return 1'b1;
    return mTxByte[off / CPB - 1];
  endfunction

  // Reference model: state after each rising edge, from the inputs of the cycle just ended.
  initial forever begin : referenceModel
    logic fetch, accept;
    @(posedge clock);
    if (reset) begin
      txQ.delete();
      rxQ.delete();
      mTxStart  = -100000;
      mTxIdleAt = 0;
      mOverrun  = 1'b0;
      mFrameErr = 1'b0;
      rxSeenSeq = rxEvtSeq;
      modelLive = 1'b1;
    end else begin
      fetch  = (cyc >= mTxIdleAt) && (txQ.size() > 0);
      accept = serialWrenIn && (txQ.size() < DEPTH);
      if (fetch) begin
        mTxByte   = txQ.pop_front();
        txLog.push_back(mTxByte);
        mTxStart  = cyc + 1;
        mTxIdleAt = cyc + 1 + FRAME;
      end
      if (accept) txQ.push_back(serialInData);
      if (serialRdenIn && rxQ.size() > 0) void'(rxQ.pop_front());
      if (rxEvtSeq != rxSeenSeq) begin
        rxSeenSeq = rxEvtSeq;
        if (!rxEvtStopOk) mFrameErr = 1'b1;
        else if (rxQ.size() < DEPTH) rxQ.push_back(rxEvtByte);
        else mOverrun = 1'b1;
      end
    end
    cyc++;
  end

  initial forever begin : comparator
    @(negedge clock);
    if (modelLive) begin
      checkOutput("uart_tx", uartTx, expectedTx());
      checkOutput("serial_ready_out", serialReadyOut, txQ.size() < DEPTH);
      if (!rxPending) begin
        checkOutput("serial_valid_out", serialValidOut, rxQ.size() > 0);
        if (rxQ.size() > 0) checkOutput("serial_out_data", serialOutData, rxQ[0]);
        checkOutput("rx_overrun", rxOverrun, mOverrun);
        checkOutput("rx_frame_err", rxFrameErr, mFrameErr);
      end
    end
  end

  task automatic advanceCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) advanceCycle();
  endtask

  task automatic writeByte(input logic [7:0] b);
    serialWrenIn = 1'b1;
    serialInData = b;
    advanceCycle();
    serialWrenIn = 1'b0;
  endtask

  task automatic rdenPulse();
    serialRdenIn = 1'b1;
    advanceCycle();
    serialRdenIn = 1'b0;
  endtask

  task automatic resetBridge();
    reset = 1'b1;
    advanceCycle();
    reset = 1'b0;
  endtask

  // Drives one 8N1 frame; the model learns of it just after the stop bit ends.
  task automatic driveRxFrame(input logic [7:0] b, input logic stopBit);
    logic [9:0] bits;
    bits = {stopBit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (i == 9) rxPending = 1'b1;
      for (int k = 0; k < CPB; k++) begin
        uartRx = bits[i];
        advanceCycle();
      end
    end
    uartRx      = 1'b1;
    rxEvtByte   = b;
    rxEvtStopOk = stopBit;
    rxEvtSeq++;
    repeat (4) advanceCycle();
    rxPending = 1'b0;
  endtask

  task automatic applyStimulus(input int iterations);
    for (int it = 0; it < iterations; it++) begin
      case ($urandom_range(0, 9))
        0: repeat ($urandom_range(5, 20)) writeByte(8'($urandom));
        1, 2, 3: writeByte(8'($urandom));
        4, 5: rdenPulse();
        6, 7: driveRxFrame(8'($urandom), $urandom_range(0, 7) != 0);
        default: repeat ($urandom_range(1, 20)) advanceCycle();
      endcase
    end
  endtask

  initial begin : mainSequence
    int n;
    advanceCycle();
    advanceCycle();
    checkOutput("reset uart_tx", uartTx, 1);
    checkOutput("reset ready", serialReadyOut, 1);
    checkOutput("reset valid", serialValidOut, 0);
    checkOutput("reset data", serialOutData, 0);
    checkOutput("reset overrun", rxOverrun, 0);
    checkOutput("reset frame_err", rxFrameErr, 0);
    reset = 1'b0;
    advanceCycle();

    n = cyc;
    writeByte(8'h48);
    checkOutput("0x48 idle at N+1", uartTx, 1);
    waitUntil(n + 2);  checkOutput("0x48 start N+2", uartTx, 0);
    waitUntil(n + 5);  checkOutput("0x48 start N+5", uartTx, 0);
    waitUntil(n + 18); checkOutput("0x48 bit3", uartTx, 1);
    waitUntil(n + 30); checkOutput("0x48 bit6", uartTx, 1);
    waitUntil(n + 34); checkOutput("0x48 bit7", uartTx, 0);
    waitUntil(n + 38); checkOutput("0x48 stop", uartTx, 1);
    waitUntil(n + 42); checkOutput("0x48 idle N+42", uartTx, 1);
    waitUntil(n + 45);

    txLog.delete();
    for (int i = 0; i < 18; i++) begin
      if (i == 16) checkOutput("ready before 17th write", serialReadyOut, 1);
      if (i == 17) checkOutput("ready after 17th write", serialReadyOut, 0);
      serialWrenIn = 1'b1;
      serialInData = 8'(i);
      advanceCycle();
    end
    serialWrenIn = 1'b0;
    repeat (18 * (FRAME + 1)) advanceCycle();
    checkOutput("tx frame count", txLog.size(), 17);
    for (int i = 0; i < txLog.size() && i < 17; i++) checkOutput("tx order", txLog[i], i);

    writeByte(8'h5A);
    writeByte(8'hC3);
    repeat (10) advanceCycle();
    resetBridge();
    checkOutput("uart_tx after reset mid-frame", uartTx, 1);
    checkOutput("ready after reset mid-frame", serialReadyOut, 1);
    repeat (2 * FRAME) advanceCycle();

    driveRxFrame(8'hA5, 1'b1);
    checkOutput("rx 0xA5 valid", serialValidOut, 1);
    checkOutput("rx 0xA5 data", serialOutData, 8'hA5);
    rdenPulse();
    checkOutput("rx valid after pop", serialValidOut, 0);

    uartRx = 1'b0;
    advanceCycle();
    uartRx = 1'b1;
    repeat (20) advanceCycle();
    checkOutput("glitch no push", serialValidOut, 0);
    checkOutput("glitch no error", rxFrameErr, 0);
    driveRxFrame(8'h3C, 1'b0);
    checkOutput("bad stop frame_err", rxFrameErr, 1);
    checkOutput("bad stop no push", serialValidOut, 0);
    driveRxFrame(8'h96, 1'b1);
    checkOutput("recovered frame data", serialOutData, 8'h96);
    rdenPulse();
    checkOutput("frame_err sticky", rxFrameErr, 1);
    resetBridge();
    checkOutput("frame_err cleared", rxFrameErr, 0);

    for (int b = 1; b <= 17; b++) driveRxFrame(8'(b), 1'b1);
    checkOutput("overrun set", rxOverrun, 1);
    checkOutput("full head", serialOutData, 8'h01);
    for (int i = 0; i < 16; i++) begin
      checkOutput("drain order", serialOutData, i + 1);
      rdenPulse();
    end
    checkOutput("drained valid", serialValidOut, 0);

    resetBridge();
    applyStimulus(80);
    repeat ((DEPTH + 2) * (FRAME + 1)) advanceCycle();
    repeat (20) rdenPulse();
    repeat (5) advanceCycle();

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
